// File: rtl/multicycle_control_unit_if.sv
// Memory handshake bundle between the multicycle control unit (master) and the
// instruction/data memory subsystem (slave).
interface multicycle_control_unit_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle RISC datapath with a
// memory-ready watchdog. Optional INSTRET_CNT_EN adds a retired-instruction counter.
module multicycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  multicycle_control_unit_if.master  bus,
  input  logic [5:0]                 op_code,
  input  logic [1:0]                 mode,
  input  logic                       alu_zero,
  output logic                       ir_write,
  output logic                       pc_write,
  output logic [1:0]                 pc_src,
  output logic [1:0]                 alu_op,
  output logic                       alu_src_b,
  output logic                       reg_write,
  output logic                       reg_dst_sel,
  output logic [1:0]                 wb_src,
  output logic                       instr_done,
  output logic                       illegal_op,
  output logic                       bus_error,
  output logic                       halted
`ifdef INSTRET_CNT_EN
  ,
  output logic [31:0]                instret_count
`endif
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_WB2    = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_AND  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ANDI = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_LW   = 6'd5;
  localparam logic [5:0] OP_SW   = 6'd6;
  localparam logic [5:0] OP_BEQ  = 6'd7;
  localparam logic [5:0] OP_BNE  = 6'd8;
  localparam logic [5:0] OP_JMP  = 6'd12;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             bus_error_reg;
  logic             waiting;
  logic             timeout;
  logic             fetch_ok;

  // While rst_n is low the state is already FETCH; masking ready keeps the
  // Mealy fetch strobes quiet so only imem_req shows during reset.
  assign fetch_ok = bus.imem_ready & rst_n;

  always_comb begin
    state_next   = state_reg;
    waiting      = 1'b0;
    timeout      = 1'b0;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_op       = 2'b00;
    alu_src_b    = 1'b0;
    reg_write    = 1'b0;
    reg_dst_sel  = 1'b0;
    wb_src       = 2'b00;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    halted       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (fetch_ok) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else begin
          waiting = 1'b1;
          if (wait_cnt_reg == WAIT_LAST) begin
            timeout    = 1'b1;
            state_next = S_HALT;
          end
        end
      end
      S_DECODE: begin
        case (op_code)
          OP_JMP: begin
            pc_write   = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
          OP_HALT: state_next = S_HALT;
          OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI, OP_BEQ, OP_BNE:
            state_next = S_EXEC;
          OP_LW, OP_SW: begin
            // Only register-indirect (00) and post-increment (01) are defined.
            if (mode[1]) begin
              illegal_op = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_EXEC;
            end
          end
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_src_b = (op_code == OP_ANDI) || (op_code == OP_ADDI) ||
                    (op_code == OP_LW)   || (op_code == OP_SW);
        if ((op_code == OP_SUB) || (op_code == OP_BEQ) || (op_code == OP_BNE))
          alu_op = 2'b01;
        else if ((op_code == OP_AND) || (op_code == OP_ANDI))
          alu_op = 2'b10;
        case (op_code)
          OP_LW, OP_SW: state_next = S_MEM;
          OP_BEQ, OP_BNE: begin
            if ((op_code == OP_BEQ) == alu_zero) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            instr_done = 1'b1;
            state_next = S_FETCH;
          end
          OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI: state_next = S_WB;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (op_code == OP_SW);
        if (bus.dmem_ready) begin
          if (op_code == OP_SW) begin
            instr_done = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else begin
          waiting = 1'b1;
          if (wait_cnt_reg == WAIT_LAST) begin
            timeout    = 1'b1;
            state_next = S_HALT;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_src    = (op_code == OP_LW) ? 2'b01 : 2'b00;
        if ((op_code == OP_LW) && (mode == 2'b01)) begin
          state_next = S_WB2;
        end else begin
          instr_done = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_WB2: begin
        reg_write   = 1'b1;
        reg_dst_sel = 1'b1;
        wb_src      = 2'b10;
        instr_done  = 1'b1;
        state_next  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FETCH;
      wait_cnt_reg  <= '0;
      bus_error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (waiting)
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      if (timeout)
        bus_error_reg <= 1'b1;
    end
  end

  assign bus_error = bus_error_reg;

`ifdef INSTRET_CNT_EN
  logic [31:0] instret_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      instret_reg <= 32'd0;
    else if (instr_done)
      instret_reg <= instret_reg + 32'd1;
  end

  assign instret_count = instret_reg;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded into
// its expected per-cycle output script, which a compare process checks every cycle.
module tb_multicycle_control_unit;
  localparam int TO = 15;

  localparam logic [5:0] AND_ = 6'd0, ADD_ = 6'd1, SUB_ = 6'd2, ANDI_ = 6'd3, ADDI_ = 6'd4;
  localparam logic [5:0] LW_ = 6'd5, SW_ = 6'd6, BEQ_ = 6'd7, BNE_ = 6'd8, JMP_ = 6'd12, HALT_ = 6'd63;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_b;
    logic       reg_write;
    logic       reg_dst_sel;
    logic [1:0] wb_src;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
    logic       halted;
  } exp_t;

  typedef struct {
    logic       imem_ready;
    logic       dmem_ready;
    logic       alu_zero;
    logic [5:0] op;
    logic [1:0] mode;
    bit         rst;
    exp_t       exp;
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_code = 6'd0;
  logic [1:0] mode = 2'd0;
  logic       alu_zero = 1'b0;
  logic       ir_write, pc_write, alu_src_b, reg_write, reg_dst_sel;
  logic       instr_done, illegal_op, bus_error, halted;
  logic [1:0] pc_src, alu_op, wb_src;
`ifdef INSTRET_CNT_EN
  logic [31:0] instret_count;
  int unsigned m_instret = 0;
`endif

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .op_code(op_code), .mode(mode), .alu_zero(alu_zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst_sel(reg_dst_sel), .wb_src(wb_src), .instr_done(instr_done),
    .illegal_op(illegal_op), .bus_error(bus_error), .halted(halted)
`ifdef INSTRET_CNT_EN
    , .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  exp_t   act;
  assign act = {bus.imem_req, bus.dmem_req, bus.dmem_we, ir_write, pc_write, pc_src,
                alu_op, alu_src_b, reg_write, reg_dst_sel, wb_src, instr_done,
                illegal_op, bus_error, halted};

  entry_t     q[$];
  entry_t     cur;
  bit         cur_valid = 1'b0;
  int         cur_idx = 0;
  int         checks = 0;
  int         errors = 0;
  bit         berr = 1'b0;
  logic [5:0] cur_op = 6'd0;
  logic [1:0] cur_mode = 2'd0;
  logic [5:0] legal_ops [10] = '{AND_, ADD_, SUB_, ANDI_, ADDI_, LW_, SW_, BEQ_, BNE_, JMP_};

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  function automatic entry_t blank();
    entry_t e;
    e.imem_ready = 1'($urandom_range(0, 1));
    e.dmem_ready = 1'($urandom_range(0, 1));
    e.alu_zero   = 1'($urandom_range(0, 1));
    e.op         = cur_op;
    e.mode       = cur_mode;
    e.rst        = 1'b0;
    e.exp        = '0;
    e.exp.bus_error = berr;
    return e;
  endfunction

  task automatic add_reset();
    entry_t e;
    berr = 1'b0;
    e = blank();
    e.rst = 1'b1;
    e.exp.imem_req = 1'b1;
    q.push_back(e);
  endtask

  task automatic add_halt();
    entry_t e;
    for (int i = 0; i < 3; i++) begin
      e = blank();
      e.exp.halted = 1'b1;
      q.push_back(e);
    end
    add_reset();
  endtask

  // Expand one instruction into its cycle-by-cycle expectations.
  task automatic build(input logic [5:0] op, input logic [1:0] md, input logic z,
                       input int iwait, input int dwait, input int abort_k);
    entry_t e;
    bit     legal;
    cur_op   = 6'($urandom);
    cur_mode = 2'($urandom);
    for (int k = 0; k < TO; k++) begin
      e = blank();
      e.exp.imem_req = 1'b1;
      if (k == iwait) begin
        e.imem_ready = 1'b1;
        e.exp.ir_write = 1'b1;
        e.exp.pc_write = 1'b1;
        q.push_back(e);
        break;
      end
      e.imem_ready = 1'b0;
      q.push_back(e);
      if (k == TO - 1) begin
        berr = 1'b1;
        add_halt();
        return;
      end
    end
    cur_op   = op;
    cur_mode = md;
    legal = (op inside {AND_, ADD_, SUB_, ANDI_, ADDI_, BEQ_, BNE_, JMP_, HALT_}) ||
            ((op inside {LW_, SW_}) && md < 2);
    e = blank();
    if (op == JMP_) begin
      e.exp.pc_write = 1'b1;
      e.exp.pc_src = 2'd2;
      e.exp.instr_done = 1'b1;
      q.push_back(e);
      return;
    end
    if (op == HALT_) begin
      q.push_back(e);
      add_halt();
      return;
    end
    if (!legal) begin
      e.exp.illegal_op = 1'b1;
      q.push_back(e);
      return;
    end
    q.push_back(e);
    e = blank();
    e.alu_zero = z;
    e.exp.alu_src_b = op inside {ANDI_, ADDI_, LW_, SW_};
    if (op inside {SUB_, BEQ_, BNE_}) e.exp.alu_op = 2'd1;
    else if (op inside {AND_, ANDI_}) e.exp.alu_op = 2'd2;
    if (op inside {BEQ_, BNE_}) begin
      if ((op == BEQ_) ? z : !z) begin
        e.exp.pc_write = 1'b1;
        e.exp.pc_src = 2'd1;
      end
      e.exp.instr_done = 1'b1;
      q.push_back(e);
      return;
    end
    q.push_back(e);
    if (op inside {LW_, SW_}) begin
      for (int k = 0; k < TO; k++) begin
        if (k == abort_k) begin
          add_reset();
          return;
        end
        e = blank();
        e.exp.dmem_req = 1'b1;
        e.exp.dmem_we = (op == SW_);
        if (k == dwait) begin
          e.dmem_ready = 1'b1;
          e.exp.instr_done = (op == SW_);
          q.push_back(e);
          break;
        end
        e.dmem_ready = 1'b0;
        q.push_back(e);
        if (k == TO - 1) begin
          berr = 1'b1;
          add_halt();
          return;
        end
      end
      if (op == SW_) return;
    end
    e = blank();
    e.exp.reg_write = 1'b1;
    e.exp.wb_src = (op == LW_) ? 2'd1 : 2'd0;
    if (op == LW_ && md == 2'd1) begin
      q.push_back(e);
      e = blank();
      e.exp.reg_write = 1'b1;
      e.exp.reg_dst_sel = 1'b1;
      e.exp.wb_src = 2'd2;
    end
    e.exp.instr_done = 1'b1;
    q.push_back(e);
  endtask

  function automatic int done_count(input int from, input int to);
    int n = 0;
    for (int i = from; i < to; i++) n += int'(q[i].exp.instr_done);
    return n;
  endfunction

  always @(negedge clk) begin
    if (cur_valid) begin
      checks++;
      if (act !== cur.exp) begin
        errors++;
        $display("FAIL outputs cycle=%0d op=%0d got=%h want=%h", cur_idx, cur.op, act, cur.exp);
      end
      if (cur.exp.instr_done || cur.exp.illegal_op)
        $display("cycle %0d: op=%0d mode=%0d %s", cur_idx, cur.op, cur.mode,
                 cur.exp.instr_done ? "retired" : "illegal");
`ifdef INSTRET_CNT_EN
      if (cur.rst) m_instret = 0;
      checks++;
      if (instret_count !== m_instret) begin
        errors++;
        $display("FAIL instret cycle=%0d got=%0d want=%0d", cur_idx, instret_count, m_instret);
      end
      if (cur.exp.instr_done) m_instret++;
`endif
    end
  end

  initial begin
    int s;
    entry_t e;
    logic [5:0] op;
    int r;
    add_reset();
    // ADD: FETCH, DECODE, EXEC, WB
    s = q.size();
    build(ADD_, 2'd0, 1'b0, 0, 0, -1);
    chk("add_cycles", q.size() - s, 4);
    chk("add_alu_op", int'(q[s+2].exp.alu_op), 0);
    chk("add_wb_reg_write", int'(q[s+3].exp.reg_write), 1);
    chk("add_done_count", done_count(s, q.size()), 1);
    // LW post-increment with 3 ready wait cycles
    s = q.size();
    build(LW_, 2'd1, 1'b0, 0, 3, -1);
    chk("lw_cycles", q.size() - s, 9);
    chk("lw_wb_src", int'(q[s+7].exp.wb_src), 1);
    chk("lw_wb2_src", int'(q[s+8].exp.wb_src), 2);
    chk("lw_done_wb2", int'(q[s+8].exp.instr_done) + 2 * done_count(s, s + 8), 1);
    // BEQ taken, BNE not taken
    s = q.size();
    build(BEQ_, 2'd0, 1'b1, 1, 0, -1);
    chk("beq_pc_src", int'(q[s+3].exp.pc_src), 1);
    s = q.size();
    build(BNE_, 2'd0, 1'b1, 0, 0, -1);
    chk("bne_pc_write", int'(q[s+2].exp.pc_write), 0);
    // Fetch timeout, then illegal opcode and illegal LW mode
    s = q.size();
    build(ADD_, 2'd0, 1'b0, 15, 0, -1);
    chk("timeout_cycles", q.size() - s, 19);
    chk("timeout_flags", int'(q[s+15].exp.halted) + 2 * int'(q[s+15].exp.bus_error), 3);
    build(6'd20, 2'd0, 1'b0, 0, 0, -1);
    build(LW_, 2'd2, 1'b0, 0, 0, -1);
    build(ADDI_, 2'd0, 1'b0, 14, 0, -1);
    // SW aborted by reset in MEM
    s = q.size();
    build(SW_, 2'd0, 1'b0, 0, 5, 2);
    chk("abort_cycles", q.size() - s, 6);
    build(JMP_, 2'd0, 1'b0, 2, 0, -1);
    build(SW_, 2'd1, 1'b0, 0, 14, -1);
    build(LW_, 2'd0, 1'b0, 0, 15, -1);
    build(HALT_, 2'd0, 1'b0, 0, 0, -1);
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) op = HALT_;
      else if (r < 8) begin
        op = 6'($urandom_range(9, 62));
        if (op == JMP_) op = 6'd13;
      end else op = legal_ops[$urandom_range(0, 9)];
      build(op, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 19) == 19) ? 15 : ($urandom_range(0, 9) == 0 ? 14 : $urandom_range(0, 2)),
            ($urandom_range(0, 19) == 19) ? 15 : ($urandom_range(0, 9) == 0 ? 14 : $urandom_range(0, 2)),
            -1);
    end
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      e = q.pop_front();
      if (!e.rst) rst_n = 1'b1;
      bus.imem_ready = e.imem_ready;
      bus.dmem_ready = e.dmem_ready;
      alu_zero = e.alu_zero;
      op_code = e.op;
      mode = e.mode;
      cur = e;
      cur_valid = 1'b1;
      cur_idx++;
      if (e.rst) begin
        #2;
        rst_n = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cur_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
